// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit buffer:
//   - APB register offsets (decoded from padd[3:2])
//   - STATUS / CTRL bit positions
//   - drain state machine encoding
// -----------------------------------------------------------------------------
package uart_pkg;

    // Register offsets, word index (padd[3:2])
    localparam logic [1:0] UART_TXF_DATA   = 2'd0;
    localparam logic [1:0] UART_TXF_STATUS = 2'd1;
    localparam logic [1:0] UART_TXF_CTRL   = 2'd2;
    localparam logic [1:0] UART_TXF_RSVD   = 2'd3;

    // STATUS bit positions (count occupies [CNT_W-1:0])
    localparam int STAT_EMPTY_BIT = 8;
    localparam int STAT_FULL_BIT  = 9;
    localparam int STAT_OVF_BIT   = 10;
    localparam int STAT_BUSY_BIT  = 11;

    // CTRL bit positions
    localparam int CTRL_ENABLE_BIT   = 0;
    localparam int CTRL_FLUSH_BIT    = 1;
    localparam int CTRL_IRQ_MASK_BIT = 2;
    localparam int CTRL_OVF_CLR_BIT  = 3;

    // Drain state machine
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } drain_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Generic single-clock FIFO shared by the UART TX and RX paths.
// A push while full is accepted only if a pop happens in the same cycle
// (the pop frees the slot). Flush clears pointers and count and wins over
// push/pop in the same cycle. Read data is the current head (show-ahead).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, wr_data   enqueue request and data
//   pop             dequeue request (ignored when empty)
//   flush           clear all entries
//   rd_data         head entry
//   count           fill level 0..DEPTH
//   full, empty     fill flags
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty     = (count_r == {CNT_W{1'b0}});
    assign full      = (count_r == CNT_W'(DEPTH));
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);
    assign rd_data   = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Pointer and fill-count state; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// APB-slave transmit buffer feeding the UART serializer. Software pushes
// bytes into a DEPTH-entry FIFO; a drain FSM hands them one at a time to the
// transmitter (tx_start pulse + tx_byte) and waits for i_tx_done.
//
// Optional feature macro: UART_TX_FIFO_IRQ_EN
//   defined   -> o_irq port, CTRL[2] irq_mask stored;
//                o_irq = irq_mask & empty & FSM idle (registered level)
//   undefined -> no o_irq port, CTRL[2] not stored, reads 0
//
// Ports:
//   pclk, rst            clock, asynchronous active-high reset
//   psel, penable,
//   pwrite, padd, pwdata APB request (padd[3:2] decoded)
//   pready, prdata,
//   pslverr              APB response (zero wait states)
//   tx_start, tx_byte    frame start pulse and byte to serialize
//   i_tx_done            frame-complete pulse from the serializer
//   o_irq                drained interrupt (UART_TX_FIFO_IRQ_EN only)
//
// Register map: 0 DATA (wo), 1 STATUS (ro), 2 CTRL, 3 reserved (pslverr).
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] padd,
    input  logic [31:0] pwdata,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr,
    output logic        tx_start,
    output logic [7:0]  tx_byte,
    input  logic        i_tx_done
`ifdef UART_TX_FIFO_IRQ_EN
    ,
    output logic        o_irq
`endif
);

    // ------------------------------------------------------------------
    // APB decode
    // ------------------------------------------------------------------
    logic       access_s;
    logic       wr_access_s;
    logic       rd_access_s;
    logic [1:0] addr_s;
    logic       push_req_s;
    logic       push_drop_s;
    logic       ctrl_wr_s;
    logic       flush_s;
    logic       rsvd_s;

    assign access_s    = psel & penable;
    assign wr_access_s = access_s & pwrite;
    assign rd_access_s = access_s & ~pwrite;
    assign addr_s      = padd[3:2];
    assign push_req_s  = wr_access_s & (addr_s == UART_TXF_DATA);
    assign ctrl_wr_s   = wr_access_s & (addr_s == UART_TXF_CTRL);
    assign flush_s     = ctrl_wr_s & pwdata[CTRL_FLUSH_BIT];
    assign rsvd_s      = access_s & (addr_s == UART_TXF_RSVD);

    logic unused_s;
    assign unused_s = ^{padd[31:4], padd[1:0], pwdata[31:8]};

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]       fifo_rdata_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             pop_s;

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (pclk),
        .rst     (rst),
        .push    (push_req_s),
        .wr_data (pwdata[7:0]),
        .pop     (pop_s),
        .flush   (flush_s),
        .rd_data (fifo_rdata_s),
        .count   (fifo_count_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // A pop in the same cycle frees a slot, so a push to a full FIFO is
    // only dropped when no pop coincides with it.
    assign push_drop_s = push_req_s & fifo_full_s & ~pop_s;

    assign pready  = access_s;
    assign pslverr = rsvd_s | push_drop_s;

    // ------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------
    logic enable_r;
    logic overflow_r;
    logic irq_mask_rd_s;

    // Enable bit, written through CTRL
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            enable_r <= 1'b0;
        end else if (ctrl_wr_s) begin
            enable_r <= pwdata[CTRL_ENABLE_BIT];
        end else begin
            enable_r <= enable_r;
        end
    end

    // Sticky overflow flag: set on a dropped push, write-1-clear via CTRL
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (push_drop_s) begin
            overflow_r <= 1'b1;
        end else if (ctrl_wr_s && pwdata[CTRL_OVF_CLR_BIT]) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // ------------------------------------------------------------------
    // Drain FSM
    // ------------------------------------------------------------------
    drain_state_e state_r;
    drain_state_e state_next_s;
    logic         tx_start_r;
    logic [7:0]   tx_byte_r;

    assign pop_s = (state_r == IDLE) & enable_r & ~fifo_empty_s;

    // State register
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; done pulses outside WAIT are ignored
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (pop_s) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                state_next_s = WAIT;
            end
            WAIT: begin
                if (i_tx_done) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // tx_start is high exactly while the FSM sits in LOAD
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            tx_start_r <= 1'b0;
        end else begin
            tx_start_r <= (state_next_s == LOAD);
        end
    end

    // Byte capture on pop; held until the next pop (flush leaves it alone)
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            tx_byte_r <= 8'd0;
        end else if (pop_s) begin
            tx_byte_r <= fifo_rdata_s;
        end else begin
            tx_byte_r <= tx_byte_r;
        end
    end

    assign tx_start = tx_start_r;
    assign tx_byte  = tx_byte_r;

    // ------------------------------------------------------------------
    // Optional drained interrupt
    // ------------------------------------------------------------------
`ifdef UART_TX_FIFO_IRQ_EN
    logic irq_mask_r;
    logic irq_r;

    // Interrupt mask, written through CTRL
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            irq_mask_r <= 1'b0;
        end else if (ctrl_wr_s) begin
            irq_mask_r <= pwdata[CTRL_IRQ_MASK_BIT];
        end else begin
            irq_mask_r <= irq_mask_r;
        end
    end

    // Level interrupt: FIFO drained and the last frame completed
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_mask_r & fifo_empty_s & (state_r == IDLE);
        end
    end

    assign o_irq         = irq_r;
    assign irq_mask_rd_s = irq_mask_r;
`else
    assign irq_mask_rd_s = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read mux: reflects register state before the current edge
    // ------------------------------------------------------------------
    logic [31:0] status_word_s;
    logic [31:0] ctrl_word_s;

    // STATUS and CTRL read words
    always_comb begin
        status_word_s                    = 32'd0;
        status_word_s[CNT_W-1:0]         = fifo_count_s;
        status_word_s[STAT_EMPTY_BIT]    = fifo_empty_s;
        status_word_s[STAT_FULL_BIT]     = fifo_full_s;
        status_word_s[STAT_OVF_BIT]      = overflow_r;
        status_word_s[STAT_BUSY_BIT]     = (state_r != IDLE);
        ctrl_word_s                      = 32'd0;
        ctrl_word_s[CTRL_ENABLE_BIT]     = enable_r;
        ctrl_word_s[CTRL_IRQ_MASK_BIT]   = irq_mask_rd_s;
    end

    // prdata is zero outside a read access phase
    always_comb begin
        prdata = 32'd0;
        if (rd_access_s) begin
            case (addr_s)
                UART_TXF_STATUS: prdata = status_word_s;
                UART_TXF_CTRL:   prdata = ctrl_word_s;
                default:         prdata = 32'd0;
            endcase
        end else begin
            prdata = 32'd0;
        end
    end

endmodule
